game_flow_ctrl: RTL

//  Top-level sequencer for the snake game. Owns the START/PLAY/END state machine and drives Game_status
//  to the snake, apple and VGA blocks. Issues the single-cycle Move_tick that paces snake motion and

---
 rtl/game_flow_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// Snake game flow sequencer: START/PLAY/END state machine, move-tick pacing
// with score-driven speed-up, and the end-of-game flash sequence.
module game_flow_ctrl #(
    parameter int unsigned TICK_INIT   = 32'd12_500_000,
    parameter int unsigned TICK_MIN    = 32'd5_000_000,
    parameter int unsigned TICK_STEP   = 32'd500_000,
    parameter int unsigned PTS_PER_LVL = 32'd4,
    parameter int unsigned FLASH_HALF  = 32'd12_500_000,
    parameter int unsigned END_TOGGLES = 32'd8
) (
    input  logic       Clk_50mhz,
    input  logic       Rst_n,
    input  logic       Key_start,
    input  logic       Hit_wall_sig,
    input  logic       Hit_body_sig,
    input  logic       Body_add_sig,
    output logic [2:0] Game_status,
    output logic       Move_tick,
    output logic       Flash_sig,
    output logic [6:0] Score,
    output logic [3:0] Speed_level
);

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] flash_cnt_q, flash_cnt_d;
    logic [31:0] toggle_cnt_q, toggle_cnt_d;
    logic [6:0]  score_q, score_d;
    logic [3:0]  speed_q, speed_d;
    logic        flash_q, flash_d;
    logic        move_tick_q, move_tick_d;
    logic        key_d_q;
    logic        add_d_q;

    logic        key_rise_s;
    logic        add_rise_s;
    logic        hit_s;
    logic        tick_due_s;
    logic [6:0]  score_inc_s;
    logic [31:0] period_dec_s;

    assign key_rise_s   = Key_start & ~key_d_q;
    assign add_rise_s   = Body_add_sig & ~add_d_q;
    assign hit_s        = Hit_wall_sig | Hit_body_sig;
    // ">=" rather than "==" so a counter left beyond a freshly shortened
    // period wraps immediately instead of running off to 2^32.
    assign tick_due_s   = (tick_cnt_q >= (period_q - 32'd1));
    assign score_inc_s  = (score_q == 7'd127) ? 7'd127 : (score_q + 7'd1);
    assign period_dec_s = (period_q >= (TICK_MIN + TICK_STEP)) ? (period_q - TICK_STEP) : TICK_MIN;

    // Next-state and datapath update for all three game phases.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        period_d     = period_q;
        flash_cnt_d  = flash_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        score_d      = score_q;
        speed_d      = speed_q;
        flash_d      = flash_q;
        move_tick_d  = 1'b0;

        case (state_q)
            ST_START: begin
                flash_d = 1'b1;
                if (key_rise_s) begin
                    state_d    = ST_PLAY;
                    score_d    = 7'd0;
                    speed_d    = 4'd0;
                    period_d   = TICK_INIT;
                    tick_cnt_d = 32'd0;
                end else begin
                    state_d = ST_START;
                end
            end

            ST_PLAY: begin
                flash_d = 1'b1;
                if (tick_due_s) begin
                    tick_cnt_d = 32'd0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 32'd1;
                end

                // A saturated score no longer changes, so it cannot trigger speed-ups.
                if (add_rise_s && (score_q != 7'd127)) begin
                    score_d = score_inc_s;
                    if ((32'(score_inc_s) % PTS_PER_LVL) == 32'd0) begin
                        period_d = period_dec_s;
                        if ((period_dec_s != period_q) && (speed_q != 4'd15)) begin
                            speed_d = speed_q + 4'd1;
                        end else begin
                            speed_d = speed_q;
                        end
                    end else begin
                        period_d = period_q;
                    end
                end else begin
                    score_d = score_q;
                end

                if (hit_s) begin
                    state_d      = ST_END;
                    flash_cnt_d  = 32'd0;
                    toggle_cnt_d = 32'd0;
                    flash_d      = 1'b0;
                    move_tick_d  = 1'b0;
                end else begin
                    move_tick_d = tick_due_s;
                end
            end

            ST_END: begin
                if (flash_cnt_q == (FLASH_HALF - 32'd1)) begin
                    flash_cnt_d = 32'd0;
                    if (toggle_cnt_q == (END_TOGGLES - 32'd1)) begin
                        toggle_cnt_d = 32'd0;
                        flash_d      = 1'b1;
                        state_d      = ST_START;
                    end else begin
                        toggle_cnt_d = toggle_cnt_q + 32'd1;
                        flash_d      = ~flash_q;
                    end
                end else begin
                    flash_cnt_d = flash_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_START;
                flash_d = 1'b1;
            end
        endcase
    end

    // State, counters, registered outputs and input edge detectors.
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_START;
            tick_cnt_q   <= 32'd0;
            period_q     <= TICK_INIT;
            flash_cnt_q  <= 32'd0;
            toggle_cnt_q <= 32'd0;
            score_q      <= 7'd0;
            speed_q      <= 4'd0;
            flash_q      <= 1'b1;
            move_tick_q  <= 1'b0;
            key_d_q      <= 1'b1;
            add_d_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            period_q     <= period_d;
            flash_cnt_q  <= flash_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
            score_q      <= score_d;
            speed_q      <= speed_d;
            flash_q      <= flash_d;
            move_tick_q  <= move_tick_d;
            key_d_q      <= Key_start;
            add_d_q      <= Body_add_sig;
        end
    end

    assign Game_status = state_q;
    assign Move_tick   = move_tick_q;
    assign Flash_sig   = flash_q;
    assign Score       = score_q;
    assign Speed_level = speed_q;

endmodule
